// File: rtl/dma_copy_engine_if.sv
// Bus bundle for dma_copy_engine: register-window slave port plus the
// memory master port and the completion interrupt.
// The slave modport is the engine's view; the master modport is the
// host/system view that drives the register window and answers the master bus.
interface dma_copy_engine_if;
  logic        cs;
  logic        data_m_access;
  logic        data_m_ack;
  logic [1:0]  data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;

  logic [18:0] dma_m_addr;
  logic [15:0] dma_m_data_out;
  logic [15:0] dma_m_data_in;
  logic        dma_m_access;
  logic        dma_m_ack;
  logic        dma_m_wr_en;
  logic [1:0]  dma_m_bytesel;

  logic        dma_intr;

  modport slave (
    input  cs, data_m_access, data_m_addr, data_m_data_in, data_m_wr_en,
           data_m_bytesel, dma_m_data_in, dma_m_ack,
    output data_m_ack, data_m_data_out, dma_m_addr, dma_m_data_out,
           dma_m_access, dma_m_wr_en, dma_m_bytesel, dma_intr
  );

  modport master (
    output cs, data_m_access, data_m_addr, data_m_data_in, data_m_wr_en,
           data_m_bytesel, dma_m_data_in, dma_m_ack,
    input  data_m_ack, data_m_data_out, dma_m_addr, dma_m_data_out,
           dma_m_access, dma_m_wr_en, dma_m_bytesel, dma_intr
  );
endinterface

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word-by-word memory copy engine with a four-register
// control window (SRC paragraph, DST paragraph, COUNT, CTRL/STATUS) and a
// registered single-outstanding master port (read, gap, write, gap, ...).
// Optional macro DMA_IRQ_EN enables the irq_en bit and the dma_intr output;
// without it dma_intr is tied low and irq_en reads 0.
module dma_copy_engine (
  input  logic             clk,
  input  logic             reset,
  dma_copy_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state;
  state_t      next_state;

  logic [15:0] src_reg;
  logic [15:0] dst_reg;
  logic [15:0] count_reg;
  logic        irq_en;
  logic        done;
  logic        abort_pend;
  logic        busy;

  logic        req;
  logic        req_seen;
  logic        ack_r;
  logic [1:0]  acc_addr;
  logic [1:0]  acc_bytesel;
  logic [15:0] acc_wdata;
  logic        acc_wr;

  logic        wr_strobe;
  logic        rd_strobe;
  logic        ctrl_wr;
  logic        start_req;
  logic        abort_req;
  logic        clear_req;
  logic [15:0] rdata;

  logic [18:0] src_w;
  logic [18:0] dst_w;
  logic [18:0] next_src_w;
  logic [18:0] next_dst_w;
  logic        complete;
  logic        count_dec;
  logic        latch_rd;
  logic        ack_hit;

  // Byte-lane merge for register writes: lane 0 = bits [7:0], lane 1 = [15:8]
  function automatic logic [15:0] merge_lanes(input logic [15:0] old_val,
                                               input logic [15:0] wdata,
                                               input logic [1:0]  sel);
    merge_lanes = {sel[1] ? wdata[15:8] : old_val[15:8],
                   sel[0] ? wdata[7:0]  : old_val[7:0]};
  endfunction

  assign busy = (state != IDLE);
  assign req  = bus.cs && bus.data_m_access;

  // Register access front end: one ack per request edge, request fields captured
  always_ff @(posedge clk) begin
    if (reset) begin
      req_seen    <= 1'b0;
      ack_r       <= 1'b0;
      acc_addr    <= 2'b00;
      acc_bytesel <= 2'b00;
      acc_wdata   <= 16'h0;
      acc_wr      <= 1'b0;
    end else begin
      req_seen <= req;
      ack_r    <= req && !req_seen;
      if (req && !req_seen) begin
        acc_addr    <= bus.data_m_addr;
        acc_bytesel <= bus.data_m_bytesel;
        acc_wdata   <= bus.data_m_data_in;
        acc_wr      <= bus.data_m_wr_en;
      end
    end
  end

  // The access is performed in the ack cycle using the captured fields
  assign wr_strobe = ack_r && acc_wr;
  assign rd_strobe = ack_r && !acc_wr;
  assign ctrl_wr   = wr_strobe && (acc_addr == 2'd3) && acc_bytesel[0];
  assign start_req = ctrl_wr && acc_wdata[0] && !busy;
  assign abort_req = ctrl_wr && acc_wdata[3] && busy;
  assign clear_req = ctrl_wr && acc_wdata[2];

  // Read mux; STATUS reports busy, irq_en and done in bits 0..2
  always_comb begin
    rdata = 16'h0;
    case (acc_addr)
      2'd0:    rdata = src_reg;
      2'd1:    rdata = dst_reg;
      2'd2:    rdata = count_reg;
      default: rdata = {13'h0, done, irq_en, busy};
    endcase
  end

  // Wired-OR bus: drive read data only during an acked read
  assign bus.data_m_ack      = ack_r;
  assign bus.data_m_data_out = rd_strobe ? rdata : 16'h0;

`ifdef DMA_IRQ_EN
  assign bus.dma_intr = done && irq_en;
`else
  assign bus.dma_intr = 1'b0;
`endif

  // Next-state logic for the copy sequencer and its working addresses
  always_comb begin
    next_state = state;
    next_src_w = src_w;
    next_dst_w = dst_w;
    complete   = 1'b0;
    count_dec  = 1'b0;
    latch_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
          if (count_reg == 16'd0) begin
            complete = 1'b1;
          end else begin
            next_state = READ;
            next_src_w = {src_reg, 3'b000};
            next_dst_w = {dst_reg, 3'b000};
          end
        end
      end
      READ: begin
        if (bus.dma_m_ack) begin
          latch_rd = 1'b1;
          if (abort_pend) begin
            next_state = IDLE;
            complete   = 1'b1;
          end else begin
            next_state = WRITE;
          end
        end
      end
      WRITE: begin
        if (bus.dma_m_ack) begin
          next_src_w = src_w + 19'd1;
          next_dst_w = dst_w + 19'd1;
          count_dec  = 1'b1;
          if ((count_reg == 16'd1) || abort_pend) begin
            next_state = IDLE;
            complete   = 1'b1;
          end else begin
            next_state = READ;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Working addresses (datapath, only meaningful while busy)
  always_ff @(posedge clk) begin
    src_w <= next_src_w;
    dst_w <= next_dst_w;
  end

  assign ack_hit = busy && bus.dma_m_ack;

  // Registered master port; access drops for one cycle after every ack
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dma_m_access   <= 1'b0;
      bus.dma_m_wr_en    <= 1'b0;
      bus.dma_m_addr     <= 19'h0;
      bus.dma_m_data_out <= 16'h0;
      bus.dma_m_bytesel  <= 2'b00;
    end else begin
      bus.dma_m_access  <= (next_state != IDLE) && !ack_hit;
      bus.dma_m_wr_en   <= (next_state == WRITE);
      bus.dma_m_addr    <= (next_state == WRITE) ? next_dst_w : next_src_w;
      bus.dma_m_bytesel <= (next_state != IDLE) ? 2'b11 : 2'b00;
      if (latch_rd) begin
        bus.dma_m_data_out <= bus.dma_m_data_in;
      end
    end
  end

  // Programmable registers and status flags; completion beats done-clear
  always_ff @(posedge clk) begin
    if (reset) begin
      src_reg    <= 16'h0;
      dst_reg    <= 16'h0;
      count_reg  <= 16'h0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      if (wr_strobe && !busy) begin
        case (acc_addr)
          2'd0:    src_reg   <= merge_lanes(src_reg,   acc_wdata, acc_bytesel);
          2'd1:    dst_reg   <= merge_lanes(dst_reg,   acc_wdata, acc_bytesel);
          2'd2:    count_reg <= merge_lanes(count_reg, acc_wdata, acc_bytesel);
          default: ;
        endcase
      end
      if (count_dec) begin
        count_reg <= count_reg - 16'd1;
      end
`ifdef DMA_IRQ_EN
      if (ctrl_wr) begin
        irq_en <= acc_wdata[1];
      end
`endif
      if (complete) begin
        done <= 1'b1;
      end else if (clear_req) begin
        done <= 1'b0;
      end
      if (next_state == IDLE) begin
        abort_pend <= 1'b0;
      end else if (abort_req) begin
        abort_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed self-checking bench for dma_copy_engine with a small memory
// responder on the master port (two-cycle ack latency, optional stall).
module tb_dma_copy_engine;

  logic clk;
  logic reset;
  dma_copy_engine_if bus();

  dma_copy_engine dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Responder / monitor state
  int          log_n = 0;
  logic        log_wr   [512];
  logic [18:0] log_addr [512];
  logic [15:0] log_data [512];
  int          stall_at = -1;
  int          viol = 0;
  int          acc_cycles = 0;
  int          wcnt = 0;
  logic        prev_acc = 1'b0;
  logic        acked_prev = 1'b0;
  logic        intr_seen = 1'b0;
  logic [18:0] hold_addr;
  logic        hold_wr;
  logic [15:0] hold_dout;

  function automatic logic [15:0] mem_word(input logic [18:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  always @(negedge clk) begin
    bus.dma_m_ack     = 1'b0;
    bus.dma_m_data_in = mem_word(bus.dma_m_addr);
    if (bus.dma_intr === 1'b1) intr_seen = 1'b1;
    if (bus.dma_m_access === 1'b1) begin
      acc_cycles++;
      if (acked_prev) viol++;
      if (prev_acc && (bus.dma_m_addr !== hold_addr || bus.dma_m_wr_en !== hold_wr ||
                       (hold_wr && bus.dma_m_data_out !== hold_dout))) viol++;
      if (bus.dma_m_bytesel !== 2'b11) viol++;
      hold_addr = bus.dma_m_addr;
      hold_wr   = bus.dma_m_wr_en;
      hold_dout = bus.dma_m_data_out;
      acked_prev = 1'b0;
      if (log_n != stall_at && !reset) begin
        if (wcnt >= 1) begin
          bus.dma_m_ack = 1'b1;
          wcnt = 0;
          acked_prev = 1'b1;
          if (log_n < 512) begin
            log_wr[log_n]   = bus.dma_m_wr_en;
            log_addr[log_n] = bus.dma_m_addr;
            log_data[log_n] = bus.dma_m_wr_en ? bus.dma_m_data_out : bus.dma_m_data_in;
          end
          log_n++;
        end else begin
          wcnt++;
        end
      end
    end else begin
      wcnt = 0;
      acked_prev = 1'b0;
    end
    prev_acc = (bus.dma_m_access === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [15:0] d, input logic [1:0] sel);
    logic got;
    got = 1'b0;
    @(negedge clk);
    bus.cs = 1'b1; bus.data_m_access = 1'b1; bus.data_m_wr_en = 1'b1;
    bus.data_m_addr = a; bus.data_m_data_in = d; bus.data_m_bytesel = sel;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus.data_m_ack === 1'b1) got = 1'b1;
    end
    check("wr_ack", {31'h0, got}, 32'h1);
    check("wr_bus_quiet", {16'h0, bus.data_m_data_out}, 32'h0);
    bus.cs = 1'b0; bus.data_m_access = 1'b0; bus.data_m_wr_en = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [15:0] d);
    logic got;
    got = 1'b0;
    d = 16'hxxxx;
    @(negedge clk);
    bus.cs = 1'b1; bus.data_m_access = 1'b1; bus.data_m_wr_en = 1'b0;
    bus.data_m_addr = a; bus.data_m_bytesel = 2'b11;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus.data_m_ack === 1'b1) begin
        got = 1'b1;
        d = bus.data_m_data_out;
      end
    end
    check("rd_ack", {31'h0, got}, 32'h1);
    bus.cs = 1'b0; bus.data_m_access = 1'b0;
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
    logic [15:0] v;
    reg_read(a, v);
    check(tag, {16'h0, v}, {16'h0, exp});
  endtask

  task automatic wait_txn(input string tag, input int target);
    int k;
    k = 0;
    while (log_n < target && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'h0, (log_n >= target)}, 32'h1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acks;
    int bad;
    int k;
    logic [15:0] ack_data;
    logic [18:0] ea;

    bus.cs = 1'b0; bus.data_m_access = 1'b0; bus.data_m_wr_en = 1'b0;
    bus.data_m_addr = 2'b00; bus.data_m_data_in = 16'h0; bus.data_m_bytesel = 2'b00;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_access",  {31'h0, bus.dma_m_access},   32'h0);
    check("rst_wr_en",   {31'h0, bus.dma_m_wr_en},    32'h0);
    check("rst_addr",    {13'h0, bus.dma_m_addr},     32'h0);
    check("rst_dout",    {16'h0, bus.dma_m_data_out}, 32'h0);
    check("rst_bytesel", {30'h0, bus.dma_m_bytesel},  32'h0);
    check("rst_ack",     {31'h0, bus.data_m_ack},     32'h0);
    check("rst_rdout",   {16'h0, bus.data_m_data_out}, 32'h0);
    check("rst_intr",    {31'h0, bus.dma_intr},       32'h0);
    reset = 1'b0;
    expect_reg("rst_src",   2'd0, 16'h0000);
    expect_reg("rst_dst",   2'd1, 16'h0000);
    expect_reg("rst_count", 2'd2, 16'h0000);
    expect_reg("rst_ctrl",  2'd3, 16'h0000);

    // Basic copy of three words
    base = log_n;
    reg_write(2'd0, 16'h1000, 2'b11);
    reg_write(2'd1, 16'h2000, 2'b11);
    reg_write(2'd2, 16'h0003, 2'b11);
    reg_write(2'd3, 16'h0001, 2'b01);
    wait_txn("copy_txns", base + 6);
    check("copy_ntxn", log_n - base, 32'd6);
    for (int i = 0; i < 3; i++) begin
      ea = 19'h08000 + 19'(i);
      check("copy_rd_dir",  {31'h0, log_wr[base + 2*i]},       32'h0);
      check("copy_rd_addr", {13'h0, log_addr[base + 2*i]},     {13'h0, ea});
      check("copy_wr_dir",  {31'h0, log_wr[base + 2*i + 1]},   32'h1);
      check("copy_wr_addr", {13'h0, log_addr[base + 2*i + 1]}, {13'h0, 19'h10000 + 19'(i)});
      check("copy_wr_data", {16'h0, log_data[base + 2*i + 1]}, {16'h0, mem_word(ea)});
    end
    expect_reg("copy_ctrl",  2'd3, 16'h0004);
    expect_reg("copy_count", 2'd2, 16'h0000);
    expect_reg("copy_src",   2'd0, 16'h1000);

    // Read of CTRL held for four cycles
    acks = 0; bad = 0; ack_data = 16'h0;
    @(negedge clk);
    bus.cs = 1'b1; bus.data_m_access = 1'b1; bus.data_m_wr_en = 1'b0;
    bus.data_m_addr = 2'd3; bus.data_m_bytesel = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.data_m_ack === 1'b1) begin
        acks++;
        ack_data = bus.data_m_data_out;
      end else if (bus.data_m_data_out !== 16'h0) begin
        bad++;
      end
      if (i == 3) begin
        bus.cs = 1'b0; bus.data_m_access = 1'b0;
      end
    end
    check("hold_acks",  acks, 32'd1);
    check("hold_quiet", bad,  32'd0);
    check("hold_data",  {16'h0, ack_data}, 32'h0004);

    // Byte lanes
    reg_write(2'd0, 16'hABCD, 2'b01);
    expect_reg("lane_src_lo", 2'd0, 16'h10CD);
    reg_write(2'd0, 16'h5678, 2'b10);
    expect_reg("lane_src_hi", 2'd0, 16'h56CD);
    reg_write(2'd3, 16'h0004, 2'b01);
    reg_write(2'd3, 16'h0001, 2'b10);
    expect_reg("lane_ctrl_ignored", 2'd3, 16'h0000);

    // Wrap-around: nine words from the highest paragraph
    base = log_n;
    reg_write(2'd0, 16'hFFFF, 2'b11);
    reg_write(2'd1, 16'h0100, 2'b11);
    reg_write(2'd2, 16'h0009, 2'b11);
    reg_write(2'd3, 16'h0001, 2'b01);
    wait_txn("wrap_txns", base + 18);
    check("wrap_rd0",  {13'h0, log_addr[base]},      32'h7FFF8);
    check("wrap_rd1",  {13'h0, log_addr[base + 2]},  32'h7FFF9);
    check("wrap_rd7",  {13'h0, log_addr[base + 14]}, 32'h7FFFF);
    check("wrap_rd8",  {13'h0, log_addr[base + 16]}, 32'h00000);
    check("wrap_wr0",  {13'h0, log_addr[base + 1]},  32'h00800);
    check("wrap_wr8",  {13'h0, log_addr[base + 17]}, 32'h00808);
    check("wrap_data8", {16'h0, log_data[base + 17]}, {16'h0, mem_word(19'h00000)});
    expect_reg("wrap_ctrl", 2'd3, 16'h0004);

    // Zero count: done without any master activity
    reg_write(2'd3, 16'h0004, 2'b01);
    reg_write(2'd2, 16'h0000, 2'b11);
    k = acc_cycles;
    reg_write(2'd3, 16'h0001, 2'b01);
    expect_reg("zero_ctrl", 2'd3, 16'h0004);
    check("zero_no_access", acc_cycles - k, 32'd0);

    // Abort during the fifth read
    reg_write(2'd3, 16'h0004, 2'b01);
    base = log_n;
    stall_at = base + 8;
    reg_write(2'd0, 16'h0200, 2'b11);
    reg_write(2'd1, 16'h0300, 2'b11);
    reg_write(2'd2, 16'd100, 2'b11);
    reg_write(2'd3, 16'h0001, 2'b01);
    k = 0;
    while (!(log_n == base + 8 && bus.dma_m_access === 1'b1) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("abort_reach_read5", {31'h0, (log_n == base + 8)}, 32'h1);
    expect_reg("abort_busy", 2'd3, 16'h0001);
    reg_write(2'd0, 16'h7777, 2'b11);
    reg_write(2'd3, 16'h0008, 2'b01);
    stall_at = -1;
    repeat (20) @(negedge clk);
    check("abort_ntxn",    log_n - base, 32'd9);
    check("abort_last_rd", {31'h0, log_wr[base + 8]},   32'h0);
    check("abort_rd_addr", {13'h0, log_addr[base + 8]}, 32'h01004);
    expect_reg("abort_count", 2'd2, 16'd96);
    expect_reg("abort_ctrl",  2'd3, 16'h0004);
    expect_reg("abort_src",   2'd0, 16'h0200);

    // Idle abort ignored, then single-word transfer with interrupt enable
    reg_write(2'd3, 16'h0004, 2'b01);
    reg_write(2'd3, 16'h0008, 2'b01);
    reg_write(2'd2, 16'h0001, 2'b11);
    base = log_n;
    reg_write(2'd3, 16'h0003, 2'b01);
    wait_txn("irq_txns", base + 2);
    check("irq_ntxn", log_n - base, 32'd2);
`ifdef DMA_IRQ_EN
    check("irq_intr_set", {31'h0, bus.dma_intr}, 32'h1);
    expect_reg("irq_ctrl", 2'd3, 16'h0006);
`else
    check("irq_intr_tied", {31'h0, bus.dma_intr}, 32'h0);
    expect_reg("irq_ctrl", 2'd3, 16'h0004);
`endif
    reg_write(2'd3, 16'h0004, 2'b01);
    @(negedge clk);
    check("irq_intr_clr", {31'h0, bus.dma_intr}, 32'h0);
    expect_reg("irq_ctrl_clr", 2'd3, 16'h0000);
`ifndef DMA_IRQ_EN
    check("irq_never", {31'h0, intr_seen}, 32'h0);
`endif

    // Reset in the middle of a write handshake
    base = log_n;
    stall_at = base + 1;
    reg_write(2'd0, 16'h0400, 2'b11);
    reg_write(2'd1, 16'h0500, 2'b11);
    reg_write(2'd2, 16'h0005, 2'b11);
    reg_write(2'd3, 16'h0001, 2'b01);
    k = 0;
    while (!(log_n == base + 1 && bus.dma_m_access === 1'b1) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("mid_reach_write", {31'h0, bus.dma_m_wr_en}, 32'h1);
    reset = 1'b1;
    stall_at = -1;
    @(negedge clk);
    check("mid_access_drop", {31'h0, bus.dma_m_access}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_access_idle", {31'h0, bus.dma_m_access}, 32'h0);
    expect_reg("mid_count", 2'd2, 16'h0000);
    expect_reg("mid_ctrl",  2'd3, 16'h0000);
    expect_reg("mid_src",   2'd0, 16'h0000);

    check("master_protocol_viol", viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous active-high reset. Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cs  in  1  register window select, decoded externally
- data_m_access  in  1  register access request
- data_m_ack  out  1  register access ack
- data_m_addr  in  2  register index (word address bits [2:1])
- data_m_data_in  in  16  register write data
- data_m_data_out  out  16  register read data
- data_m_wr_en  in  1  register write
- data_m_bytesel  in  2  register byte lanes
- dma_m_addr  out  19  master word address [19:1]
- dma_m_data_out  out  16  master write data
- dma_m_data_in  in  16  master read data
- dma_m_access  out  1  master request
- dma_m_ack  in  1  master completion, single-cycle pulse
- dma_m_wr_en  out  1  master write
- dma_m_bytesel  out  2  master byte lanes
- dma_intr  out  1  completion interrupt, level

Function
REQ-002 Registers by index: 0 SRC paragraph, bits [19:4]; 1 DST paragraph; 2 COUNT in words; 3 CTRL/STATUS.
REQ-003 CTRL write bits: 0 start, 1 irq_en, 2 done-clear (write 1), 3 abort. CTRL read bits: 0 busy, 1 irq_en, 2 done; all other bits read 0.
REQ-004 data_m_ack SHALL pulse for exactly one cycle, one cycle after a cycle with cs && data_m_access. It SHALL NOT re-pulse while the request is held past the ack.
REQ-005 data_m_data_out SHALL be 16'h0 in every cycle except an acked read cycle, because it feeds a wired-OR bus.
REQ-006 Register writes SHALL update only the lanes selected by data_m_bytesel. CTRL bits take effect only if lane 0 is selected.
REQ-007 While busy, writes to SRC, DST and COUNT SHALL be ignored, and CTRL start SHALL be ignored.
REQ-008 Start with COUNT=0 SHALL set done in the same cycle the write takes effect and SHALL NOT assert busy.
REQ-009 Start with COUNT>0 SHALL load the working source address {SRC,3'b000} and the working destination address {DST,3'b000}, then enter READ.
REQ-010 FSM states are IDLE, READ, WRITE.
- IDLE -> READ on valid start.
- READ: dma_m_access=1, dma_m_wr_en=0, dma_m_addr=working source. On dma_m_ack, latch dma_m_data_in and go to WRITE.
- WRITE: dma_m_access=1, dma_m_wr_en=1, dma_m_addr=working destination, dma_m_data_out=latched word. On dma_m_ack: increment both addresses, decrement COUNT; if COUNT becomes 0 or abort is pending, go to IDLE and set done, else go to READ.
REQ-011 Master outputs SHALL be registered and SHALL stay stable while dma_m_access=1.
REQ-012 dma_m_access SHALL be 0 in the cycle after each ack; there is a one-cycle gap between consecutive transactions.
REQ-013 dma_m_bytesel SHALL be 2'b11 whenever dma_m_access=1.
REQ-014 Working addresses SHALL increment modulo 2^19, so 19'h7FFFF wraps to 19'h00000.
REQ-015 Abort while busy SHALL NOT cut an outstanding handshake. The current transaction completes, then the FSM goes to IDLE and sets done.
- An abort in READ SHALL skip the WRITE and leave COUNT unchanged.
- Abort while idle SHALL be ignored.
REQ-016 Reading COUNT SHALL return the remaining word count. Reading SRC/DST SHALL return the programmed values, not the working addresses.
REQ-017 When a CTRL done-clear and a completion occur in the same cycle, the completion SHALL win and done SHALL be 1.
REQ-018 busy SHALL equal (state != IDLE).

Reset
REQ-019 Reset SHALL force the following:
- state IDLE
- SRC, DST and COUNT = 0
- irq_en, done and the abort-pending flag = 0
- data_m_ack = 0, data_m_data_out = 0
- dma_m_access = 0, dma_m_wr_en = 0, dma_m_addr = 0, dma_m_data_out = 0, dma_m_bytesel = 0
- dma_intr = 0
REQ-020 Reset asserted mid-transfer SHALL drop dma_m_access in the next cycle, regardless of any outstanding ack. A dma_m_ack arriving after reset SHALL be ignored.

Configuration
REQ-021 Macro DMA_IRQ_EN:
- Defined: dma_intr = done && irq_en, and irq_en is writable and readable.
- Undefined: dma_intr is tied 0, irq_en bit reads 0, and writes to it are ignored.

Verification
REQ-022 Basic copy: SRC=16'h1000, DST=16'h2000, COUNT=3, start -> 3 read/write pairs, reads at 19'h08000..08002, writes at 19'h10000..10002 with the read data; then done=1, busy=0, COUNT reads 0.
REQ-023 Wrap-around: SRC=16'hFFFF, COUNT=2 -> reads at 19'h7FFF8 and 19'h7FFF9. SRC=16'hFFFF is the highest paragraph; a copy starting there reaches 19'h7FFFF only after 8 words.
REQ-024 Zero count: COUNT=0, start -> done=1 one cycle after the ack, dma_m_access never asserted.
REQ-025 Abort: COUNT=100, assert abort during the 5th READ -> that read completes and no write follows; IDLE, COUNT reads 96, done=1.
REQ-026 Interrupt (DMA_IRQ_EN defined): irq_en=1, COUNT=1 transfer -> dma_intr=1 after the write ack; writing CTRL=16'h0004 clears it to 0. Macro undefined -> dma_intr stays 0 throughout.
REQ-027 Register bus hygiene: a read of index 3 held for 4 cycles -> exactly one ack pulse, and data_m_data_out is nonzero only in the ack cycle. A write of SRC while busy -> SRC unchanged.
